// File: rtl/calc_arbiter.sv
// Round-robin front end that shares one calculator between two requesters.
// It issues one operation at a time and returns a tagged, registered response.
module calc_arbiter #(
  parameter int COMB_WAIT      = 1,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  REQ,
  input  logic [7:0]  A0,
  input  logic [7:0]  B0,
  input  logic [1:0]  OP0,
  input  logic [7:0]  A1,
  input  logic [7:0]  B1,
  input  logic [1:0]  OP1,
  output logic [1:0]  ACK,
  output logic        BUSY,
  output logic        RSP_VALID,
  output logic        RSP_ID,
  output logic [15:0] RSP_RESULT,
  output logic        RSP_DBZ,
  output logic        RSP_TIMEOUT,
  output logic [7:0]  CALC_A,
  output logic [7:0]  CALC_B,
  output logic [1:0]  CALC_OP,
  output logic        CALC_START,
  input  logic [15:0] CALC_RESULT,
  input  logic        CALC_DONE,
  input  logic        CALC_DBZ
);

  localparam int MAXC = (COMB_WAIT > TIMEOUT_CYCLES) ? COMB_WAIT : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    COMB_WAIT_S,
    DIV_WAIT,
    RESPOND
  } state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          rspValid_q, rspValid_d;
  logic          rspId_q, rspId_d;
  logic [15:0]   rspResult_q, rspResult_d;
  logic          rspDbz_q, rspDbz_d;
  logic          rspTimeout_q, rspTimeout_d;
  logic [7:0]    calcA_q, calcA_d;
  logic [7:0]    calcB_q, calcB_d;
  logic [1:0]    calcOp_q, calcOp_d;
  logic          calcStart_q, calcStart_d;
  logic          winner;

  // Outputs are one cycle ahead of the state they describe, so ACK and
  // CALC_START are decided on the IDLE sample edge and appear during ISSUE.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    ack_d        = 2'b00;
    rspValid_d   = 1'b0;
    rspId_d      = rspId_q;
    rspResult_d  = rspResult_q;
    rspDbz_d     = rspDbz_q;
    rspTimeout_d = rspTimeout_q;
    calcA_d      = calcA_q;
    calcB_d      = calcB_q;
    calcOp_d     = calcOp_q;
    calcStart_d  = 1'b0;
    winner       = ptr_q;

    unique case (state_q)
      IDLE: begin
        if (REQ != 2'b00) begin
          winner      = REQ[ptr_q] ? ptr_q : ~ptr_q;
          calcA_d     = winner ? A1 : A0;
          calcB_d     = winner ? B1 : B0;
          calcOp_d    = winner ? OP1 : OP0;
          rspId_d     = winner;
          ack_d       = winner ? 2'b10 : 2'b01;
          calcStart_d = ((winner ? OP1 : OP0) == 2'b11);
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = (calcOp_q == 2'b11) ? DIV_WAIT : COMB_WAIT_S;
      end
      COMB_WAIT_S: begin
        if (cnt_q == CW'(COMB_WAIT - 1)) begin
          rspResult_d  = CALC_RESULT;
          rspDbz_d     = 1'b0;
          rspTimeout_d = 1'b0;
          rspValid_d   = 1'b1;
          state_d      = RESPOND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DIV_WAIT: begin
        if (CALC_DONE) begin
          rspResult_d  = CALC_RESULT;
          rspDbz_d     = CALC_DBZ;
          rspTimeout_d = 1'b0;
          rspValid_d   = 1'b1;
          state_d      = RESPOND;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rspResult_d  = 16'hFFFF;
          rspDbz_d     = 1'b0;
          rspTimeout_d = 1'b1;
          rspValid_d   = 1'b1;
          state_d      = RESPOND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESPOND: begin
        ptr_d   = ~rspId_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      cnt_q        <= '0;
      ack_q        <= 2'b00;
      busy_q       <= 1'b0;
      rspValid_q   <= 1'b0;
      rspId_q      <= 1'b0;
      rspResult_q  <= 16'h0000;
      rspDbz_q     <= 1'b0;
      rspTimeout_q <= 1'b0;
      calcA_q      <= 8'h00;
      calcB_q      <= 8'h00;
      calcOp_q     <= 2'b00;
      calcStart_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      rspValid_q   <= rspValid_d;
      rspId_q      <= rspId_d;
      rspResult_q  <= rspResult_d;
      rspDbz_q     <= rspDbz_d;
      rspTimeout_q <= rspTimeout_d;
      calcA_q      <= calcA_d;
      calcB_q      <= calcB_d;
      calcOp_q     <= calcOp_d;
      calcStart_q  <= calcStart_d;
    end
  end

  assign ACK         = ack_q;
  assign BUSY        = busy_q;
  assign RSP_VALID   = rspValid_q;
  assign RSP_ID      = rspId_q;
  assign RSP_RESULT  = rspResult_q;
  assign RSP_DBZ     = rspDbz_q;
  assign RSP_TIMEOUT = rspTimeout_q;
  assign CALC_A      = calcA_q;
  assign CALC_B      = calcB_q;
  assign CALC_OP     = calcOp_q;
  assign CALC_START  = calcStart_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// Scoreboard bench for calc_arbiter with a small behavioural calculator
// whose divide DONE arrives a programmable number of cycles after start.
module tb_calc_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  REQ;
  logic [7:0]  A0, B0, A1, B1;
  logic [1:0]  OP0, OP1;
  logic [1:0]  ACK;
  logic        BUSY, RSP_VALID, RSP_ID, RSP_DBZ, RSP_TIMEOUT;
  logic [15:0] RSP_RESULT;
  logic [7:0]  CALC_A, CALC_B;
  logic [1:0]  CALC_OP;
  logic        CALC_START;
  logic [15:0] CALC_RESULT;
  logic        CALC_DONE, CALC_DBZ;

  int          checksTotal = 0;
  int          checksPassed = 0;
  logic [18:0] expQ[$];
  int          divDelay = 0;
  logic [5:0]  divCnt;

  always #5 clk = ~clk;

  calc_arbiter #(.COMB_WAIT(1), .TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .REQ(REQ),
    .A0(A0), .B0(B0), .OP0(OP0), .A1(A1), .B1(B1), .OP1(OP1),
    .ACK(ACK), .BUSY(BUSY), .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID),
    .RSP_RESULT(RSP_RESULT), .RSP_DBZ(RSP_DBZ), .RSP_TIMEOUT(RSP_TIMEOUT),
    .CALC_A(CALC_A), .CALC_B(CALC_B), .CALC_OP(CALC_OP), .CALC_START(CALC_START),
    .CALC_RESULT(CALC_RESULT), .CALC_DONE(CALC_DONE), .CALC_DBZ(CALC_DBZ)
  );

  // Calculator stand-in: divide DONE pulses divDelay cycles after the start
  // pulse; a delay of 0 means DONE never arrives.
  always @(posedge clk) begin
    if (rst)                divCnt <= 6'd0;
    else if (CALC_START)    divCnt <= divDelay[5:0];
    else if (divCnt != 6'd0) divCnt <= divCnt - 6'd1;
  end
  assign CALC_DONE = (divCnt == 6'd1);

  always_comb begin
    CALC_RESULT = 16'h0000;
    CALC_DBZ    = 1'b0;
    case (CALC_OP)
      2'b00: CALC_RESULT = {8'h00, CALC_A} + {8'h00, CALC_B};
      2'b01: CALC_RESULT = {8'h00, CALC_A} - {8'h00, CALC_B};
      2'b10: CALC_RESULT = {8'h00, CALC_A} * {8'h00, CALC_B};
      default: begin
        CALC_DBZ    = (CALC_B == 8'h00);
        CALC_RESULT = (CALC_B == 8'h00) ? 16'h0000 : {8'h00, CALC_A / CALC_B};
      end
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Monitor: every response strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (RSP_VALID) begin
      if (expQ.size() == 0) checkOutput("unexpected_rsp", 32'd1, 32'd0);
      else checkOutput("rsp", {13'd0, RSP_ID, RSP_DBZ, RSP_TIMEOUT, RSP_RESULT},
                       {13'd0, expQ.pop_front()});
    end
  end

  // Waits for IDLE, raises reqMask, then tracks ACK, start pulses and latency
  // (cycles from the IDLE sample) until the response strobe.
  task automatic applyStimulus(input logic [1:0] reqMask, input logic [1:0] expAck,
                               input int expLat, input logic [15:0] expRes,
                               input logic expDbz, input logic expTo);
    int   starts = 0;
    int   lat = -1;
    logic isDiv;
    isDiv = expAck[1] ? (OP1 == 2'b11) : (OP0 == 2'b11);
    for (int w = 0; w < 100 && BUSY; w++) @(negedge clk);
    expQ.push_back({expAck[1], expDbz, expTo, expRes});
    REQ = reqMask;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("ack", {30'd0, ACK}, {30'd0, expAck});
        checkOutput("start_cycle1", {31'd0, CALC_START}, {31'd0, isDiv});
        REQ = REQ & ~expAck;
      end
      if (CALC_START) starts++;
      if (RSP_VALID) begin
        lat = k;
        break;
      end
    end
    checkOutput("latency", lat, expLat);
    checkOutput("start_pulses", starts, {31'd0, isDiv});
  endtask

  initial begin
    rst = 1'b1; REQ = 2'b00;
    A0 = 8'd0; B0 = 8'd0; OP0 = 2'b00; A1 = 8'd0; B1 = 8'd0; OP1 = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("rst_ack", {30'd0, ACK}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    checkOutput("rst_rsp_result", {16'd0, RSP_RESULT}, 32'd0);
    checkOutput("rst_calc", {14'd0, CALC_A, CALC_B, CALC_OP}, 32'd0);
    checkOutput("rst_start", {31'd0, CALC_START}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single requests, then a contested sequence that must alternate.
    A0 = 8'd10; B0 = 8'd5; OP0 = 2'b00;
    applyStimulus(2'b01, 2'b01, 3, 16'd15, 1'b0, 1'b0);
    A1 = 8'd10; B1 = 8'd5; OP1 = 2'b10;
    applyStimulus(2'b10, 2'b10, 3, 16'd50, 1'b0, 1'b0);
    OP0 = 2'b01; OP1 = 2'b00;
    applyStimulus(2'b11, 2'b01, 3, 16'd5, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b10, 3, 16'd15, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b01, 3, 16'd5, 1'b0, 1'b0);

    // Divide paths: normal, divide-by-zero, and timeout with a late DONE.
    A0 = 8'd13; B0 = 8'd4; OP0 = 2'b11; divDelay = 9;
    applyStimulus(2'b01, 2'b01, 11, 16'd3, 1'b0, 1'b0);
    A0 = 8'd20; B0 = 8'd0; divDelay = 3;
    applyStimulus(2'b01, 2'b01, 5, 16'd0, 1'b1, 1'b0);
    A1 = 8'd100; B1 = 8'd7; OP1 = 2'b11; divDelay = 40;
    applyStimulus(2'b10, 2'b10, 34, 16'hFFFF, 1'b0, 1'b1);
    A0 = 8'd200; B0 = 8'd100; OP0 = 2'b00;
    applyStimulus(2'b01, 2'b01, 3, 16'd300, 1'b0, 1'b0);
    A1 = 8'd255; B1 = 8'd255; OP1 = 2'b10;
    applyStimulus(2'b10, 2'b10, 3, 16'd65025, 1'b0, 1'b0);
    A0 = 8'd1; B0 = 8'd1; OP0 = 2'b00;
    applyStimulus(2'b01, 2'b01, 3, 16'd2, 1'b0, 1'b0);

    // Reset in DIV_WAIT with the pointer at 1: no response, pointer back to 0.
    A0 = 8'd50; B0 = 8'd5; OP0 = 2'b11; divDelay = 0;
    for (int w = 0; w < 100 && BUSY; w++) @(negedge clk);
    REQ = 2'b01;
    @(negedge clk);
    checkOutput("div_rst_ack", {30'd0, ACK}, 32'd1);
    REQ = 2'b00;
    repeat (2) @(negedge clk);
    checkOutput("div_wait_busy", {31'd0, BUSY}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("midrst_start", {31'd0, CALC_START}, 32'd0);
    checkOutput("midrst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    checkOutput("midrst_rsp_result", {16'd0, RSP_RESULT}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    A0 = 8'd7; B0 = 8'd8; OP0 = 2'b00; A1 = 8'd1; B1 = 8'd2; OP1 = 2'b00;
    applyStimulus(2'b11, 2'b01, 3, 16'd15, 1'b0, 1'b0);
    REQ = 2'b00;

    repeat (4) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
Name: calc_arbiter

Overview:
Two-requester round-robin controller that shares one calculator_top instance (8-bit A/B, 2-bit OP, start/DONE handshake for divide).
- Accepts one operation at a time and drives the calculator operand and opcode registers.
- Sequences the wait: a fixed settle for ADD/SUB/MUL; a start pulse plus DONE wait (with timeout) for DIV.
- Returns a tagged response to the winning requester.

Parameters:
COMB_WAIT, 1, cycles held in COMB_WAIT before capturing CALC_RESULT for OP 00/01/10 (>=1)
TIMEOUT_CYCLES, 32, maximum cycles spent in DIV_WAIT before forcing a timeout response (>=2)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
REQ  input  2  REQ[i]=1: requester i has a valid operation; held until ACK[i]
A0, B0  input  8 each  requester 0 operands
OP0  input  2  requester 0 opcode (00 ADD, 01 SUB, 10 MUL, 11 DIV)
A1, B1  input  8 each  requester 1 operands
OP1  input  2  requester 1 opcode
ACK  output  2  one-cycle pulse: request i accepted, operands latched
BUSY  output  1  high in every state except IDLE
RSP_VALID  output  1  one-cycle response strobe
RSP_ID  output  1  requester index of the response
RSP_RESULT  output  16  captured result
RSP_DBZ  output  1  divide-by-zero flag of the response
RSP_TIMEOUT  output  1  DIV timed out
CALC_A, CALC_B  output  8 each  registered operands to calculator
CALC_OP  output  2  registered opcode to calculator
CALC_START  output  1  one-cycle divide start pulse
CALC_RESULT  input  16  calculator RESULT
CALC_DONE  input  1  calculator DONE
CALC_DBZ  input  1  calculator DIV_BY_ZERO

Behaviour:
- All outputs are registered.
- Reset (rst=1 at an edge, any state):
  - State goes to IDLE; the round-robin pointer goes to 0.
  - All outputs clear to 0, including CALC_A/B/OP and RSP_RESULT.
  - An in-flight operation is discarded with no RSP_VALID. CALC_START is never left high.
- IDLE:
  - Requests are sampled. If REQ is nonzero, the winner is the pointer index when REQ[ptr]=1, otherwise the other index.
  - The winner's A/B/OP are latched into CALC_A/B/OP. The latched index becomes RSP_ID. Go to ISSUE.
  - If REQ is zero, stay in IDLE.
- ISSUE (1 cycle): ACK[winner]=1.
  - If CALC_OP==11: CALC_START=1, counter cleared, go to DIV_WAIT.
  - Otherwise: counter cleared, go to COMB_WAIT.
- COMB_WAIT:
  - The counter increments each cycle.
  - In the cycle where the count reaches COMB_WAIT-1: RSP_RESULT<=CALC_RESULT, RSP_DBZ<=0, RSP_TIMEOUT<=0, go to RESPOND.
- DIV_WAIT:
  - CALC_START=0. CALC_DONE and CALC_DBZ are sampled only in this state.
  - First cycle with CALC_DONE=1: RSP_RESULT<=CALC_RESULT, RSP_DBZ<=CALC_DBZ, RSP_TIMEOUT<=0, go to RESPOND.
  - If no DONE is seen and the count equals TIMEOUT_CYCLES-1: RSP_RESULT<=16'hFFFF, RSP_DBZ<=0, RSP_TIMEOUT<=1, go to RESPOND.
  - Otherwise the count increments.
- RESPOND (1 cycle): RSP_VALID=1. The pointer becomes the inverse of the served index. Go to IDLE.
- RSP_RESULT, RSP_ID, RSP_DBZ and RSP_TIMEOUT hold their values until the next capture.
- Latency, counting the IDLE sample cycle as 0:
  - ACK at cycle 1.
  - ADD/SUB/MUL: RSP_VALID at cycle 2+COMB_WAIT.
  - DIV: CALC_START at cycle 1; RSP_VALID one cycle after DONE is first sampled high, or at cycle 2+TIMEOUT_CYCLES on timeout.
- Simultaneous REQ=11: the pointer winner is served; the loser is served next because the pointer flips.
- Continuous REQ from both requesters alternates strictly 0,1,0,1.
- REQ changes while BUSY=1 are ignored. Operands are never re-sampled mid-operation.
- A late CALC_DONE arriving after a timeout is ignored outside DIV_WAIT.
- Widths: the 16-bit CALC_RESULT is passed through unmodified. The arbiter does no arithmetic.

Test Plan:
- Reset, then REQ=01, A0=10, B0=5, OP0=00 -> ACK=01 at cycle 1; RSP_VALID at cycle 3; RSP_ID=0, RSP_RESULT=15, DBZ=0.
- REQ=10, A1=10, B1=5, OP1=10 -> RSP_ID=1, RSP_RESULT=50; the next request from requester 0 wins (pointer=0).
- REQ=11 held, OP0=01 (10-5), OP1=00 (10+5) -> responses in order ID0=5, ID1=15, ID0=5; ACK never sets both bits.
- Requester 0: DIV 13/4, calculator asserts DONE 9 cycles after start -> exactly one CALC_START pulse; RSP_RESULT=3, DBZ=0; RSP_VALID one cycle after DONE.
- DIV 20/0 -> RSP_DBZ=1, RSP_TIMEOUT=0. Separately, DIV with DONE held low -> RSP_VALID at cycle 34, RSP_TIMEOUT=1, RSP_RESULT=16'hFFFF.
- rst asserted during DIV_WAIT -> next cycle BUSY=0, CALC_START=0, no RSP_VALID; pointer=0 on the next contested request.
